ex_muldiv: RTL and testbench

- Parametrised successor to the single-op execute stage.
- Performs the full RV32I OP/OP-IMM integer ALU set combinationally in the EX slot.
- Adds the RV32M multiply/divide group through an iterative one-bit-per-cycle unit.
- Requests a pipeline stall from ctrl while a mul/div is in flight, and drives the EX/MEM write-back fields.

---
 rtl/ex_muldiv.sv | 247 ++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// RV32I OP/OP-IMM execute stage with an iterative RV32M multiply/divide unit.
// Latency: ALU 0 cycles; mul/div XLEN+1 stall cycles (1 for div-by-zero/overflow) then one DONE cycle.
// Backpressure: stall_req_o holds IF/ID/EX while the mul/div unit is busy; inputs must stay stable meanwhile.
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [INST_W-1:0] ex_inst,
    input  logic [XLEN-1:0]   s_op1_i,
    input  logic [XLEN-1:0]   s_op2_i,
    input  logic [REG_AW-1:0] reg_waddr_i,
    input  logic              reg_we_i,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic              reg_we_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              stall_req_o
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Instruction field decode
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic           is_mop;
    logic           is_alu;
    logic           is_sub;
    logic [SHW-1:0] shamt;

    assign opcode = ex_inst[6:0];
    assign funct3 = ex_inst[14:12];
    assign funct7 = ex_inst[31:25];
    assign is_mop = (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    assign is_alu = (opcode == OPC_OP_IMM) || ((opcode == OPC_OP) && !is_mop);
    // Only the register form has SUB; an ADDI with a negative immediate also has bit 30 set
    assign is_sub = (opcode == OPC_OP) && funct7[5];
    assign shamt  = s_op2_i[SHW-1:0];

    // Register fields (rd/rs1/rs2) are resolved upstream; only the opcode fields matter here
    logic unused_inst;
    assign unused_inst = ^ex_inst;

    // Combinational single-cycle ALU
    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        if (is_alu) begin
            case (funct3)
                3'b000:  alu_res = is_sub ? (s_op1_i - s_op2_i) : (s_op1_i + s_op2_i);
                3'b001:  alu_res = s_op1_i << shamt;
                3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(s_op1_i) < $signed(s_op2_i))};
                3'b011:  alu_res = {{(XLEN-1){1'b0}}, (s_op1_i < s_op2_i)};
                3'b100:  alu_res = s_op1_i ^ s_op2_i;
                3'b101:  alu_res = funct7[5] ? XLEN'($signed(s_op1_i) >>> shamt) : (s_op1_i >> shamt);
                3'b110:  alu_res = s_op1_i | s_op2_i;
                default: alu_res = s_op1_i & s_op2_i;
            endcase
        end
    end

    // Launch-time operand conditioning: magnitudes, result sign and short-circuit detection
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            res_neg;
    logic            div_zero;
    logic            div_ovf;
    always_comb begin
        a_sgn    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        a_mag    = (a_sgn && s_op1_i[XLEN-1]) ? (-s_op1_i) : s_op1_i;
        b_mag    = (b_sgn && s_op2_i[XLEN-1]) ? (-s_op2_i) : s_op2_i;
        // Remainder follows the dividend; products and quotients follow the operand sign product
        if (funct3 == 3'b110)
            res_neg = s_op1_i[XLEN-1];
        else
            res_neg = (a_sgn && s_op1_i[XLEN-1]) ^ (b_sgn && s_op2_i[XLEN-1]);
        div_zero = funct3[2] && (s_op2_i == '0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (s_op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (s_op2_i == '1);
    end

    // Unit state
    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [REG_AW-1:0] waddr_q;
    logic              we_q;

    // One iteration of shift-add multiply or restoring divide on the shared product register.
    // Multiply: low half holds the multiplier, high half accumulates. Divide: low half holds the
    // dividend shifting out and quotient bits shifting in, high half holds the partial remainder.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_next  = {div_rem, prod_q[XLEN-2:0], div_ge};
    end

    logic unused_div;
    assign unused_div = div_diff[XLEN];

    // Sign correction and result selection, driven from latched state during DONE
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   done_res;
    always_comb begin
        prod_fix = neg_q ? (-prod_q) : prod_q;
        quo_fix  = neg_q ? (-prod_q[XLEN-1:0]) : prod_q[XLEN-1:0];
        rem_fix  = neg_q ? (-prod_q[2*XLEN-1:XLEN]) : prod_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:        done_res = prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:        done_res = prod_fix[2*XLEN-1:XLEN];
            3'b100,
            3'b101:        done_res = quo_fix;
            default:       done_res = rem_fix;
        endcase
    end

    // FSM: launch from IDLE, iterate in BUSY, present the result for one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            count   <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mop) begin
                        f3_q    <= funct3;
                        waddr_q <= reg_waddr_i;
                        we_q    <= reg_we_i;
                        if (div_zero) begin
                            // Quotient all ones, remainder is the raw dividend
                            prod_q <= {s_op1_i, {XLEN{1'b1}}};
                            neg_q  <= 1'b0;
                            state  <= DONE;
                        end else if (div_ovf) begin
                            // Quotient is the dividend, remainder zero
                            prod_q <= {{XLEN{1'b0}}, s_op1_i};
                            neg_q  <= 1'b0;
                            state  <= DONE;
                        end else begin
                            prod_q  <= {{XLEN{1'b0}}, a_mag};
                            mcand_q <= b_mag;
                            neg_q   <= res_neg;
                            count   <= CW'(XLEN-1);
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prod_q <= f3_q[2] ? div_next : mul_next;
                    count  <= count - 1'b1;
                    if (count == '0)
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back and stall outputs; reset forces everything low immediately
    always_comb begin
        reg_waddr_o = '0;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        stall_req_o = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    reg_waddr_o = reg_waddr_i;
                    if (is_mop) begin
                        stall_req_o = !flush_i;
                    end else begin
                        reg_we_o    = reg_we_i && !flush_i;
                        reg_wdata_o = alu_res;
                    end
                end
                BUSY: begin
                    reg_waddr_o = waddr_q;
                    stall_req_o = !flush_i;
                end
                DONE: begin
                    reg_waddr_o = waddr_q;
                    reg_we_o    = we_q && !flush_i;
                    reg_wdata_o = done_res;
                end
                default: begin
                    reg_waddr_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a behavioural reference model and per-cycle output checks.
// Latency: model predicts stall length from operation class; one compare process runs each negedge.
// Backpressure: inputs are held for the whole predicted stall window, as the pipeline controller would.
module tb_ex_muldiv;

    localparam int XLEN = 32;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] OPR = 7'h33;
    localparam logic [6:0] FM  = 7'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] ex_inst = '0;
    logic [31:0] s_op1_i = '0;
    logic [31:0] s_op2_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_req_o;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(XLEN), .REG_AW(5), .INST_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .ex_inst     (ex_inst),
        .s_op1_i     (s_op1_i),
        .s_op2_i     (s_op2_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .stall_req_o (stall_req_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle expectations consumed by the compare process
    logic        chk_en  = 1'b0;
    logic        chk_st  = 1'b0;
    logic        chk_we  = 1'b0;
    logic        chk_dat = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;
    string       cur = "idle";

    always @(negedge clk) begin
        if (chk_en) begin
            if (chk_st)  chk({cur, "/stall"}, {31'd0, stall_req_o}, {31'd0, exp_stall});
            if (chk_we)  chk({cur, "/we"},    {31'd0, reg_we_o},    {31'd0, exp_we});
            if (chk_dat) begin
                chk({cur, "/waddr"}, {27'd0, reg_waddr_o}, {27'd0, exp_waddr});
                chk({cur, "/wdata"}, reg_wdata_o, exp_wdata);
            end
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    // Architectural result plus number of stall cycles the operation must take
    function automatic logic [31:0] model(input logic [31:0] inst, input logic [31:0] a,
                                          input logic [31:0] b, output int lat);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        logic        ovf;
        int          sh;
        opc = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b[4:0]);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        lat = 0;
        if (opc == OPR && f7 == FM) begin
            lat = XLEN + 1;
            case (f3)
                3'd0: begin p = 64'(sa * sb); return p[31:0]; end
                3'd1: begin p = 64'(sa * sb); return p[63:32]; end
                3'd2: begin p = 64'(sa) * {32'd0, b}; return p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
                3'd4: begin
                    if (b == 0) begin lat = 1; return 32'hFFFF_FFFF; end
                    if (ovf) lat = 1;
                    p = 64'(sa / sb); return p[31:0];
                end
                3'd5: begin
                    if (b == 0) begin lat = 1; return 32'hFFFF_FFFF; end
                    return a / b;
                end
                3'd6: begin
                    if (b == 0) begin lat = 1; return a; end
                    if (ovf) lat = 1;
                    p = 64'(sa % sb); return p[31:0];
                end
                default: begin
                    if (b == 0) begin lat = 1; return a; end
                    return a % b;
                end
            endcase
        end else if (opc == OPI || opc == OPR) begin
            case (f3)
                3'd0: return (opc == OPR && f7[5]) ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: begin
                    if (f7[5]) begin p = 64'(sa >>> sh); return p[31:0]; end
                    return a >> sh;
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        return 32'd0;
    endfunction

    // Present one instruction (called at posedge+1) and hold it for its whole predicted duration
    task automatic run_op(input string name, input logic [31:0] inst, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic we,
                          input logic [31:0] hand);
        logic [31:0] mv;
        int          lat;
        mv = model(inst, a, b, lat);
        chk({name, "/model"}, mv, hand);
        cur = name;
        ex_inst = inst; s_op1_i = a; s_op2_i = b; reg_waddr_i = rd; reg_we_i = we;
        for (int k = 0; k < lat; k++) begin
            exp_stall = 1'b1; exp_we = 1'b0;
            chk_st = 1'b1; chk_we = 1'b1; chk_dat = 1'b0; chk_en = 1'b1;
            @(posedge clk); #1;
        end
        exp_stall = 1'b0; exp_we = we; exp_waddr = rd; exp_wdata = mv;
        chk_st = 1'b1; chk_we = 1'b1; chk_dat = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        ex_inst = '0; reg_we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst/stall", {31'd0, stall_req_o}, 32'd0);
        chk("rst/we",    {31'd0, reg_we_o},    32'd0);
        chk("rst/waddr", {27'd0, reg_waddr_o}, 32'd0);
        chk("rst/wdata", reg_wdata_o,          32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // ALU path
        run_op("addi",  enc(7'h7F, 3'd0, OPI), 32'h5,          32'hFFFF_FFFD, 5'd1,  1'b1, 32'h0000_0002);
        run_op("sra",   enc(7'h20, 3'd5, OPR), 32'h8000_0010,  32'h4,         5'd2,  1'b1, 32'hF800_0001);
        run_op("srai",  enc(7'h20, 3'd5, OPI), 32'h8000_0010,  32'h4,         5'd3,  1'b1, 32'hF800_0001);
        run_op("srl",   enc(7'h00, 3'd5, OPR), 32'h8000_0010,  32'h4,         5'd4,  1'b1, 32'h0800_0001);
        run_op("sub",   enc(7'h20, 3'd0, OPR), 32'h5,          32'h7,         5'd5,  1'b1, 32'hFFFF_FFFE);
        run_op("slt",   enc(7'h00, 3'd2, OPR), 32'hFFFF_FFFF,  32'h1,         5'd6,  1'b1, 32'h1);
        run_op("sltu",  enc(7'h00, 3'd3, OPR), 32'hFFFF_FFFF,  32'h1,         5'd7,  1'b1, 32'h0);
        run_op("sll",   enc(7'h00, 3'd1, OPR), 32'h1,          32'h25,        5'd8,  1'b1, 32'h20);
        run_op("xor",   enc(7'h00, 3'd4, OPR), 32'hF0F0,       32'h0FF0,      5'd9,  1'b1, 32'hFF00);
        run_op("or",    enc(7'h00, 3'd6, OPR), 32'hF0F0,       32'h0FF0,      5'd10, 1'b1, 32'hFFF0);
        run_op("and",   enc(7'h00, 3'd7, OPR), 32'hF0F0,       32'h0FF0,      5'd11, 1'b1, 32'h00F0);
        run_op("unsup", enc(7'h00, 3'd0, 7'h03), 32'h5,        32'h6,         5'd12, 1'b1, 32'h0);

        // Multiply
        run_op("mulh",   enc(FM, 3'd1, OPR), 32'hFFFF_FFFE, 32'h3,         5'd13, 1'b1, 32'hFFFF_FFFF);
        run_op("mul",    enc(FM, 3'd0, OPR), 32'hFFFF_FFFE, 32'h3,         5'd14, 1'b1, 32'hFFFF_FFFA);
        run_op("mulhu",  enc(FM, 3'd3, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'hFFFF_FFFE);
        run_op("mulhsu", enc(FM, 3'd2, OPR), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'hFFFF_FFFF);
        run_op("mul_nowe", enc(FM, 3'd0, OPR), 32'h7,       32'h6,         5'd17, 1'b0, 32'h2A);

        // Divide / remainder including short-circuit cases
        run_op("div",    enc(FM, 3'd4, OPR), 32'hFFFF_FFF9, 32'h2,         5'd18, 1'b1, 32'hFFFF_FFFD);
        run_op("rem",    enc(FM, 3'd6, OPR), 32'hFFFF_FFF9, 32'h2,         5'd19, 1'b1, 32'hFFFF_FFFF);
        run_op("div_pn", enc(FM, 3'd4, OPR), 32'h7,         32'hFFFF_FFFE, 5'd20, 1'b1, 32'hFFFF_FFFD);
        run_op("rem_pn", enc(FM, 3'd6, OPR), 32'h7,         32'hFFFF_FFFE, 5'd21, 1'b1, 32'h1);
        run_op("divu",   enc(FM, 3'd5, OPR), 32'd100,       32'd7,         5'd22, 1'b1, 32'hE);
        run_op("remu",   enc(FM, 3'd7, OPR), 32'd100,       32'd7,         5'd23, 1'b1, 32'h2);
        run_op("divu_z", enc(FM, 3'd5, OPR), 32'h7,         32'h0,         5'd24, 1'b1, 32'hFFFF_FFFF);
        run_op("rem_z",  enc(FM, 3'd6, OPR), 32'hFFFF_FFF9, 32'h0,         5'd25, 1'b1, 32'hFFFF_FFF9);
        run_op("rem_ov", enc(FM, 3'd6, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 5'd26, 1'b1, 32'h0);
        run_op("div_ov", enc(FM, 3'd4, OPR), 32'h8000_0000, 32'hFFFF_FFFF, 5'd27, 1'b1, 32'h8000_0000);

        // Flush during BUSY: no write pulse, then an ADD runs normally with stall low
        cur = "flush";
        ex_inst = enc(FM, 3'd5, OPR); s_op1_i = 32'd100; s_op2_i = 32'd7;
        reg_waddr_i = 5'd28; reg_we_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_stall = 1'b1; exp_we = 1'b0;
            chk_st = 1'b1; chk_we = 1'b1; chk_dat = 1'b0; chk_en = 1'b1;
            @(posedge clk); #1;
        end
        flush_i = 1'b1; exp_we = 1'b0; chk_st = 1'b0; chk_we = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        run_op("flush_add", enc(7'h00, 3'd0, OPR), 32'd5, 32'd6, 5'd29, 1'b1, 32'd11);

        // Asynchronous reset in the middle of a multiply
        cur = "rst_mul";
        ex_inst = enc(FM, 3'd0, OPR); s_op1_i = 32'd9; s_op2_i = 32'd9;
        reg_waddr_i = 5'd30; reg_we_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_stall = 1'b1; exp_we = 1'b0;
            chk_st = 1'b1; chk_we = 1'b1; chk_dat = 1'b0; chk_en = 1'b1;
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst/stall", {31'd0, stall_req_o}, 32'd0);
        chk("arst/we",    {31'd0, reg_we_o},    32'd0);
        chk("arst/waddr", {27'd0, reg_waddr_o}, 32'd0);
        chk("arst/wdata", reg_wdata_o,          32'd0);
        ex_inst = '0; reg_we_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_op("mul_after_rst", enc(FM, 3'd0, OPR), 32'd3, 32'd4, 5'd31, 1'b1, 32'h0000_000C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
